// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared definitions for the gate1 observe/control TDR.
//   TDR_WIDTH  : functional/override data width used by the update-register struct
//   SEL_BIT, STICKY_BIT, DATA_LSB : field positions inside the shift chain
//   chain_len(): shift chain length for a given data width, with or without parity
//   upd_reg_t  : update register (select, sticky mode, override data)
package firebird7_in_gate1_tessent_tdr_pkg;

  localparam int TDR_WIDTH  = 3;

  localparam int SEL_BIT    = 0;
  localparam int STICKY_BIT = 1;
  localparam int DATA_LSB   = 2;

  // The parity bit, when present, sits just above the data field.
  function automatic int chain_len(input int width, input bit parity);
    return width + 2 + (parity ? 1 : 0);
  endfunction

  typedef struct packed {
    logic                 select;
    logic                 sticky;
    logic [TDR_WIDTH-1:0] data;
  } upd_reg_t;

endpackage

// File: rtl/firebird7_in_gate1_tessent_sticky_acc.sv
// Sticky-OR accumulator for the observe side of the TDR.
//   clk, rst_n   : IJTAG clock, asynchronous active-low reset
//   sticky_mode  : accumulate while high, held at zero while low
//   capture      : a capture edge starts a fresh window (acc cleared)
//   data_in      : functional value ORed in every cycle
//   acc          : accumulated value (excludes the current cycle's data_in)
module firebird7_in_gate1_tessent_sticky_acc #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sticky_mode,
  input  logic             capture,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] acc
);

  // Accumulation runs regardless of whether the TDR is selected, so the
  // observation window covers every functional cycle since the last capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (!sticky_mode || capture) begin
      acc <= '0;
    end else begin
      acc <= acc | data_in;
    end
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_observe_w3.sv
// IJTAG TDR driving the control side (select + override data) of the 3-bit
// functional/IJTAG mux and capturing the functional data for observation,
// either live or as a sticky-OR over the window since the last capture.
// Optional build macro: FIREBIRD7_IN_GATE1_TDR_PARITY_EN adds a parity bit at
// the top of the chain and the ijtag_parity_err output.
// Ports:
//   ijtag_tck, ijtag_reset       : clock (rising edge), async active-low reset
//   ijtag_sel/ce/se/ue           : select, capture, shift, update enables
//   ijtag_si, ijtag_so           : scan in, registered scan out (chain bit 0)
//   functional_data_in [WIDTH]   : functional value being observed
//   ijtag_select                 : mux select from the update register
//   ijtag_data_out [WIDTH]       : override data from the update register
//   ijtag_parity_err             : (parity build) last update rejected
// Chain layout: bit 0 select, bit 1 sticky mode, bits [WIDTH+1:2] data,
// then the parity bit in the parity build.
module firebird7_in_gate1_tessent_tdr_observe_w3
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int WIDTH = TDR_WIDTH
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic             ijtag_select,
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  output logic             ijtag_parity_err,
`endif
  output logic [WIDTH-1:0] ijtag_data_out
);

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif
  localparam int CHAIN_LEN = chain_len(WIDTH, PARITY);

  logic [CHAIN_LEN-1:0] shift_q;
  logic [CHAIN_LEN-1:0] cap_vec;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     cap_data;
  upd_reg_t             upd_q;
  logic                 capture;
  logic                 shift_en;
  logic                 update_en;
  logic                 upd_ok;

  // Simultaneous enables resolve as ce > se > ue.
  assign capture   = ijtag_sel & ijtag_ce;
  assign shift_en  = ijtag_sel & ~ijtag_ce & ijtag_se;
  assign update_en = ijtag_sel & ~ijtag_ce & ~ijtag_se & ijtag_ue;

  firebird7_in_gate1_tessent_sticky_acc #(
    .WIDTH (WIDTH)
  ) u_sticky_acc (
    .clk         (ijtag_tck),
    .rst_n       (ijtag_reset),
    .sticky_mode (upd_q.sticky),
    .capture     (capture),
    .data_in     (functional_data_in),
    .acc         (acc)
  );

  // Sticky capture includes this cycle's data; the accumulator clears on
  // the same edge so the next window starts clean.
  assign cap_data = upd_q.sticky ? (acc | functional_data_in) : functional_data_in;

  always_comb begin
    cap_vec                     = '0;
    cap_vec[SEL_BIT]            = upd_q.select;
    cap_vec[STICKY_BIT]         = upd_q.sticky;
    cap_vec[DATA_LSB +: WIDTH]  = cap_data;
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    cap_vec[CHAIN_LEN-1]        = ^cap_data;
`endif
  end

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  assign upd_ok = ((^shift_q[DATA_LSB +: WIDTH]) == shift_q[CHAIN_LEN-1]);
`else
  assign upd_ok = 1'b1;
`endif

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      shift_q <= '0;
    end else if (capture) begin
      shift_q <= cap_vec;
    end else if (shift_en) begin
      shift_q <= {ijtag_si, shift_q[CHAIN_LEN-1:1]};
    end
  end

  // A chain with bad parity leaves the update register untouched.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      upd_q <= '0;
    end else if (update_en && upd_ok) begin
      upd_q.select <= shift_q[SEL_BIT];
      upd_q.sticky <= shift_q[STICKY_BIT];
      upd_q.data   <= shift_q[DATA_LSB +: WIDTH];
    end
  end

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ijtag_parity_err <= 1'b0;
    end else if (update_en) begin
      ijtag_parity_err <= ~upd_ok;
    end
  end
`endif

  assign ijtag_so       = shift_q[SEL_BIT];
  assign ijtag_select   = upd_q.select;
  assign ijtag_data_out = upd_q.data;

endmodule
